// File: rtl/aes_key_schedule_gen.sv
// Word-serial AES-128/192/256 key expansion. One schedule word is produced per
// cycle into an internal store. Round keys are read back through a registered
// port that is indexed by round.
module aes_key_schedule_gen #(
  parameter int unsigned MAX_NK    = 8,
  parameter int unsigned MAX_WORDS = 4*(MAX_NK+7)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [MAX_NK*32-1:0] key,
  output logic                busy,
  output logic                ready,
  output logic                error,
  output logic [3:0]          nr,
  input  logic [3:0]          rk_addr,
  output logic [127:0]        rk_data,
  output logic                rk_valid
);

  localparam int unsigned AW = $clog2(MAX_WORDS);

  // AES S-box, byte 0x00 first.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   store [MAX_WORDS];
  logic [AW-1:0] i;
  logic [2:0]    j;      // i mod Nk, tracked incrementally instead of dividing
  logic [7:0]    rcon;
  logic [3:0]    nk;
  logic [3:0]    nk_sel, nr_sel;
  logic          key_ok, accept, reject;
  logic [AW-1:0] last_idx;
  logic [31:0]   w_prev, w_back, sub_in, sub_out, t, w_new;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign busy     = (state == EXPAND);
  assign ready    = (state == DONE);
  assign last_idx = AW'({nr, 2'b11});

  // Decode the requested key length and check it against the store size.
  always_comb begin
    nk_sel = 4'd0;
    nr_sel = 4'd0;
    case (key_len)
      2'd0: begin nk_sel = 4'd4; nr_sel = 4'd10; end
      2'd1: begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'd2: begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: ;
    endcase
    key_ok = (key_len != 2'd3) && (32'(nk_sel) <= MAX_NK);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and start acceptance/rejection.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (key_ok) begin
            accept    = 1'b1;
            state_nxt = EXPAND;
          end else begin
            reject = 1'b1;
          end
        end
      end
      EXPAND: if (i == last_idx) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next schedule word from w[i-1] and w[i-Nk].
  always_comb begin
    w_prev  = store[i - AW'(1)];
    w_back  = store[i - AW'(nk)];
    sub_in  = (j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (j == 3'd0)                     t = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4)  t = sub_out;
    else                               t = w_prev;
    w_new = w_back ^ t;
  end

  // Word store: key load on accept, one generated word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        for (int unsigned k = 0; k < MAX_NK; k++)
          if (k < 32'(nk_sel)) store[k] <= key[MAX_NK*32-1-32*k -: 32];
      end else if (state == EXPAND) begin
        store[i] <= w_new;
      end
    end
  end

  // Expansion counters, status outputs and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      error    <= 1'b0;
      nr       <= 4'd0;
      nk       <= 4'd0;
      i        <= '0;
      j        <= '0;
      rcon     <= 8'h01;
      rk_data  <= '0;
      rk_valid <= 1'b0;
    end else begin
      error <= reject;
      if (accept) begin
        nr   <= nr_sel;
        nk   <= nk_sel;
        i    <= AW'(nk_sel);
        j    <= '0;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        i <= i + AW'(1);
        j <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
      end
      if (ready && rk_addr <= nr) begin
        rk_data  <= {store[AW'({rk_addr, 2'b00})], store[AW'({rk_addr, 2'b01})],
                     store[AW'({rk_addr, 2'b10})], store[AW'({rk_addr, 2'b11})]};
        rk_valid <= 1'b1;
      end else begin
        rk_data  <= '0;
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
// Directed bench for aes_key_schedule_gen using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         busy, ready, error;
  logic [3:0]   nr;
  logic [3:0]   rk_addr = 4'd0;
  logic [127:0] rk_data;
  logic         rk_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_gen #(.MAX_NK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .ready(ready), .error(error), .nr(nr),
    .rk_addr(rk_addr), .rk_data(rk_data), .rk_valid(rk_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and count edges (start edge included) until ready, bounded.
  task automatic expand(input logic [1:0] kl, input logic [255:0] k, output int edges);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!ready && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] d, output logic v);
    rk_addr = a;
    tick();
    d = rk_data;
    v = rk_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, ready, error, rk_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/ready/error/rk_valid=%b required 0000", {busy, ready, error, rk_valid});
    end
    checks++;
    if (nr !== 4'd0 || rk_data !== '0) begin
      errors++;
      $display("FAIL reset_data: nr=%0d rk_data=%h required 0", nr, rk_data);
    end
  endtask

  task automatic test_aes128();
    int e;
    logic [127:0] d;
    logic v;
    expand(2'd0, K128, e);
    checks++;
    if (e !== 41 || busy !== 1'b0) begin
      errors++;
      $display("FAIL aes128_latency: edges=%0d busy=%b required 41/0", e, busy);
    end
    checks++;
    if (nr !== 4'd10) begin errors++; $display("FAIL aes128_nr: %0d required 10", nr); end
    read_rk(4'd0, d, v);
    checks++;
    if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c || v !== 1'b1) begin
      errors++;
      $display("FAIL aes128_rk0: %h v=%b required 2b7e151628aed2a6abf7158809cf4f3c v=1", d, v);
    end
    read_rk(4'd1, d, v);
    checks++;
    if (d !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1) begin
      errors++;
      $display("FAIL aes128_rk1: %h v=%b required a0fafe1788542cb123a339392a6c7605 v=1", d, v);
    end
    read_rk(4'd10, d, v);
    checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin
      errors++;
      $display("FAIL aes128_rk10: %h v=%b required d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v);
    end
    read_rk(4'd11, d, v);
    checks++;
    if (d !== '0 || v !== 1'b0) begin
      errors++;
      $display("FAIL aes128_rk11_oob: %h v=%b required 0 v=0", d, v);
    end
  endtask

  task automatic test_invalid_keylen();
    logic [127:0] d;
    logic v;
    key_len = 2'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b1 || ready !== 1'b1 || nr !== 4'd10) begin
      errors++;
      $display("FAIL reject_pulse: error=%b ready=%b nr=%0d required 1/1/10", error, ready, nr);
    end
    tick();
    checks++;
    if (error !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reject_one_cycle: error=%b ready=%b required 0/1", error, ready);
    end
    read_rk(4'd10, d, v);
    checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin
      errors++;
      $display("FAIL reject_store_kept: %h v=%b required d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v);
    end
  endtask

  task automatic test_aes192();
    int e;
    logic [127:0] d;
    logic v;
    expand(2'd1, K192, e);
    checks++;
    if (e !== 47 || nr !== 4'd12) begin
      errors++;
      $display("FAIL aes192_latency: edges=%0d nr=%0d required 47/12", e, nr);
    end
    read_rk(4'd0, d, v);
    checks++;
    if (d !== 128'h8e73b0f7da0e6452c810f32b809079e5 || v !== 1'b1) begin
      errors++;
      $display("FAIL aes192_rk0: %h v=%b required 8e73b0f7da0e6452c810f32b809079e5 v=1", d, v);
    end
    read_rk(4'd12, d, v);
    checks++;
    if (d !== 128'he98ba06f448c773c8ecc720401002202 || v !== 1'b1) begin
      errors++;
      $display("FAIL aes192_rk12: %h v=%b required e98ba06f448c773c8ecc720401002202 v=1", d, v);
    end
    read_rk(4'd13, d, v);
    checks++;
    if (d !== '0 || v !== 1'b0) begin
      errors++;
      $display("FAIL aes192_rk13_oob: %h v=%b required 0 v=0", d, v);
    end
  endtask

  task automatic test_aes256();
    int e;
    logic [127:0] d;
    logic v;
    expand(2'd2, K256, e);
    checks++;
    if (e !== 53 || nr !== 4'd14) begin
      errors++;
      $display("FAIL aes256_latency: edges=%0d nr=%0d required 53/14", e, nr);
    end
    read_rk(4'd1, d, v);
    checks++;
    if (d !== 128'h1f352c073b6108d72d9810a30914dff4 || v !== 1'b1) begin
      errors++;
      $display("FAIL aes256_rk1: %h v=%b required 1f352c073b6108d72d9810a30914dff4 v=1", d, v);
    end
    read_rk(4'd14, d, v);
    checks++;
    if (d !== 128'hfe4890d1e6188d0b046df344706c631e || v !== 1'b1) begin
      errors++;
      $display("FAIL aes256_rk14: %h v=%b required fe4890d1e6188d0b046df344706c631e v=1", d, v);
    end
  endtask

  task automatic test_start_during_expand();
    int e;
    logic [127:0] d;
    logic v;
    key_len = 2'd0;
    key     = K128;
    rk_addr = 4'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    e = 1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL rekey_edge: busy=%b ready=%b rk_valid=%b required 1/0/1", busy, ready, rk_valid);
    end
    repeat (5) begin tick(); e++; end
    checks++;
    if (rk_valid !== 1'b0 || rk_data !== '0) begin
      errors++;
      $display("FAIL expand_read: rk_valid=%b rk_data=%h required 0/0", rk_valid, rk_data);
    end
    key_len = 2'd2;
    key     = K256;
    start   = 1'b1;
    tick();
    e++;
    start = 1'b0;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || nr !== 4'd10) begin
      errors++;
      $display("FAIL expand_start_ignored: error=%b busy=%b nr=%0d required 0/1/10", error, busy, nr);
    end
    while (!ready && e < 200) begin tick(); e++; end
    checks++;
    if (e !== 41) begin
      errors++;
      $display("FAIL expand_ignore_latency: edges=%0d required 41", e);
    end
    read_rk(4'd10, d, v);
    checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin
      errors++;
      $display("FAIL expand_ignore_rk10: %h v=%b required d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v);
    end
  endtask

  task automatic test_reset_mid_expand();
    int e;
    logic [127:0] d;
    logic v;
    key_len = 2'd2;
    key     = K256;
    rk_addr = 4'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, ready, error, rk_valid} !== 4'b0000 || nr !== 4'd0 || rk_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy/ready/error/rk_valid=%b nr=%0d rk_data=%h required 0000/0/0",
               {busy, ready, error, rk_valid}, nr, rk_data);
    end
    start   = 1'b1;
    key_len = 2'd0;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b ready=%b required 0/0", busy, ready);
    end
    expand(2'd0, K128, e);
    checks++;
    if (e !== 41 || nr !== 4'd10) begin
      errors++;
      $display("FAIL post_reset_latency: edges=%0d nr=%0d required 41/10", e, nr);
    end
    read_rk(4'd10, d, v);
    checks++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rk10: %h v=%b required d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_invalid_keylen();
    test_aes192();
    test_aes256();
    test_start_during_expand();
    test_reset_mid_expand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
